// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
// State encoding, requester ids and default parameter values.
package imem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FETCH_RUN = 2'd1,
    DBG_RUN   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    REQ_NONE  = 2'd0,
    REQ_FETCH = 2'd1,
    REQ_DBG   = 2'd2
  } req_id_e;

  localparam int              DEF_ADDR_WIDTH      = 32;
  localparam int              DEF_DATA_WIDTH      = 32;
  localparam longint unsigned DEF_MEM_BYTES       = 64'd1 << 20;
  localparam int              DEF_FETCH_BURST_MAX = 4;

endpackage

// File: rtl/imem_resp_reg.sv
// Per-requester response register: rvalid/rdata/err with load enable.
// Ports: clk, rst_n, load, data_in, err_in -> rvalid, rdata, err.
module imem_resp_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  err_in,
  output logic                  rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err
);

  logic                  rvalid_d, rvalid_q;
  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  err_d, err_q;

  // rvalid pulses only on the cycle after a load; data/err hold otherwise
  always_comb begin
    rvalid_d = load;
    rdata_d  = rdata_q;
    err_d    = err_q;
    if (load) begin
      rdata_d = data_in;
      err_d   = err_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

endmodule

// File: rtl/imem_port_arbiter.sv
// Arbitrates the imem read port between fetch and debug requesters.
// Ports: fetch_*/dbg_* req/addr/gnt/rvalid/rdata/err, mem_addr, mem_rdata.
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int              ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int              DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter longint unsigned MEM_BYTES       = DEF_MEM_BYTES,
  parameter int              FETCH_BURST_MAX = DEF_FETCH_BURST_MAX
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_req,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [DATA_WIDTH-1:0] fetch_rdata,
  output logic                  fetch_err,
  input  logic                  dbg_req,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic                  dbg_gnt,
  output logic                  dbg_rvalid,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(FETCH_BURST_MAX + 1);
  localparam logic [CW-1:0] FMAX = CW'(FETCH_BURST_MAX);

  arb_state_e            state_q;
  logic [CW-1:0]         fcnt_d, fcnt_q;
  req_id_e               win;
  logic                  gnt_f, gnt_d;
  logic [ADDR_WIDTH-1:0] gaddr;
  logic                  addr_err;
  logic [DATA_WIDTH-1:0] cap_data;
  logic                  f_rv, d_rv;

  // Debug wins when fetch is idle or has used up its burst
  always_comb begin
    gnt_d = rst_n & dbg_req & (~fetch_req | (fcnt_q == FMAX));
    gnt_f = rst_n & fetch_req & ~gnt_d;
    win   = REQ_NONE;
    unique case (1'b1)
      gnt_f:   win = REQ_FETCH;
      gnt_d:   win = REQ_DBG;
      default: win = REQ_NONE;
    endcase
  end

  always_comb begin
    gaddr = '0;
    unique case (win)
      REQ_FETCH: gaddr = fetch_addr;
      REQ_DBG:   gaddr = dbg_addr;
      default:   gaddr = '0;
    endcase
  end

  assign mem_addr = {gaddr[ADDR_WIDTH-1:2], 2'b00};

  always_comb begin
    addr_err = (gaddr[1:0] != 2'b00) || (64'(gaddr) >= MEM_BYTES);
    cap_data = addr_err ? '0 : mem_rdata;
  end

  // Burst counter only runs while debug is actually waiting
  always_comb begin
    fcnt_d = fcnt_q;
    if (!dbg_req || gnt_d) begin
      fcnt_d = '0;
    end else if (gnt_f && (fcnt_q != FMAX)) begin
      fcnt_d = fcnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      unique case (win)
        REQ_FETCH: state_q <= FETCH_RUN;
        REQ_DBG:   state_q <= DBG_RUN;
        default:   state_q <= IDLE;
      endcase
    end
  end

  imem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_fetch_resp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gnt_f),
    .data_in (cap_data),
    .err_in  (addr_err),
    .rvalid  (f_rv),
    .rdata   (fetch_rdata),
    .err     (fetch_err)
  );

  imem_resp_reg #(.DATA_WIDTH(DATA_WIDTH)) u_dbg_resp (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (gnt_d),
    .data_in (cap_data),
    .err_in  (addr_err),
    .rvalid  (d_rv),
    .rdata   (dbg_rdata),
    .err     (dbg_err)
  );

  // Last-cycle winner state and per-port valid agree by construction
  assign fetch_gnt    = gnt_f;
  assign dbg_gnt      = gnt_d;
  assign fetch_rvalid = f_rv & (state_q == FETCH_RUN);
  assign dbg_rvalid   = d_rv & (state_q == DBG_RUN);

endmodule

// File: doc/imem_port_arbiter.md
# imem_port_arbiter

Shares the single combinational instruction-memory read port between the core's fetch unit and the debug/loader port. Grants at most one requester per cycle, drives the memory word address and returns a registered response with an error flag for misaligned or out-of-range addresses. Fetch has default priority. A consecutive-grant limit keeps debug from being starved. Sits between the fetch stage/debug module and the instruction memory.

## Interface
- ADDR_WIDTH, 32, byte-address width of both requesters and the memory port
- DATA_WIDTH, 32, instruction word width
- MEM_BYTES, 1<<20, memory size in bytes; addresses >= MEM_BYTES are errors
- FETCH_BURST_MAX, 4, consecutive fetch grants allowed while debug is pending (>=1)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_req  in  1  fetch request; addr held stable until granted
- fetch_addr  in  ADDR_WIDTH  fetch byte address
- fetch_gnt  out  1  fetch granted this cycle (combinational)
- fetch_rvalid  out  1  fetch response valid, one cycle after grant
- fetch_rdata  out  DATA_WIDTH  fetch response word
- fetch_err  out  1  fetch response error (qualified by rvalid)
- dbg_req, dbg_addr, dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err: same directions, widths and meanings for the debug requester
- mem_addr  out  ADDR_WIDTH  byte address to memory, word aligned (bits [1:0] = 0)
- mem_rdata  in  DATA_WIDTH  combinational memory read data for mem_addr

## Operation
- State machine, reset value IDLE:
  - IDLE: no grant last cycle.
  - FETCH_RUN: fetch granted last cycle.
  - DBG_RUN: debug granted last cycle.
- Starvation counter fcnt counts 0..FETCH_BURST_MAX. It increments on each fetch grant while dbg_req=1 and saturates. It clears on any debug grant or any cycle with dbg_req=0.
- Grant rule, evaluated each cycle:
  - If dbg_req and (fetch_req=0 or fcnt==FETCH_BURST_MAX): grant debug.
  - Else if fetch_req: grant fetch.
  - Else: no grant.
- Next state: grant fetch -> FETCH_RUN; grant debug -> DBG_RUN; no grant -> IDLE.
- mem_addr = {granted addr[ADDR_WIDTH-1:2], 2'b00}. It is 0 when there is no grant.
- Error when granted addr[1:0] != 0 or addr >= MEM_BYTES. On error, rdata is registered as 0. Never z.
- Response registers capture on each clock edge:
  - The winning requester's rvalid goes to 1, with rdata = mem_rdata (or 0 on error) and err.
  - The other requester's rvalid goes to 0; its rdata and err hold.

## Timing
- Grant is same-cycle and combinational from req, state and fcnt. No combinational path exists from mem_rdata to any output.
- Read latency: exactly 1 cycle from grant to rvalid. Back-to-back grants give one response per cycle to the same requester.
- Simultaneous requests with fcnt < FETCH_BURST_MAX: fetch wins and debug waits.
- With debug pending continuously, the grant pattern is FETCH_BURST_MAX fetches, then 1 debug, repeating.
- A requester dropping req without a grant is legal. No response is generated.
- Reset values: all rvalid=0, all err=0, all rdata=0, fcnt=0, state=IDLE.
- Reset mid-operation: an in-flight response is discarded. rvalid is 0 from reset assertion until the first grant after release.
- Both gnt outputs are 0 while rst_n=0.

## Structure
- Shared package `imem_arb_pkg`: state enum (IDLE, FETCH_RUN, DBG_RUN), requester-id enum (REQ_NONE, REQ_FETCH, REQ_DBG), default parameter constants.
- One sub-module, `imem_resp_reg`, instantiated twice: per-requester response register (rvalid/rdata/err) with load enable and async clear.
- The address-check logic (alignment and range) is inline.

## Test plan
- Single fetch: fetch_req=1, addr=0x0000_0010, mem word 4 = 0x0010_0093 -> fetch_gnt=1 that cycle, mem_addr=0x10; next cycle fetch_rvalid=1, rdata=0x0010_0093, err=0.
- Misaligned and range errors:
  - dbg_addr=0x0000_0006 -> dbg_rvalid=1, dbg_err=1, rdata=0.
  - dbg_addr=0x0010_0000 with MEM_BYTES=1<<20 -> err=1.
- Contention with FETCH_BURST_MAX=4: both req held high for 10 cycles -> grants F,F,F,F,D,F,F,F,F,D. No cycle has both gnt=1.
- Idle debug: dbg_req=1, fetch_req=0 -> debug granted every cycle, fcnt stays 0. Raising fetch_req then gives fetch the next grant.
- Reset mid-flight: grant fetch, assert rst_n=0 before the next edge -> fetch_rvalid stays 0; after release, all outputs are at reset values and the first grant is serviced normally.
- Streaming: fetch addresses 0,4,8,12 on consecutive cycles -> rvalid=1 for 4 consecutive cycles with matching words in order.
